frame_cfg_sched: RTL and testbench

//  Frame-synchronous configuration scheduler for the image-preprocessing ASIC.

---
 rtl/asic_pkg.sv | 21 ++
 rtl/frame_cfg_sched_sync_edge_det.sv | 21 ++
 rtl/frame_cfg_sched.sv | 157 +++++++++++++++
 tb/tb_frame_cfg_sched.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asic_pkg.sv
// Shared types and constants for the frame-synchronous configuration scheduler.
// Holds the FSM encoding, the datapath select codes and the mode-to-path mapping.
package asic_pkg;

  localparam int CFG_W_DEF = 8;

  localparam logic [1:0] SEL_BYPASS = 2'b00;
  localparam logic [1:0] SEL_GREY   = 2'b01;

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Codes 10/11 are reserved and fall back to bypass.
  function automatic logic [1:0] path_of(input logic [1:0] mode);
    return (mode == SEL_GREY) ? SEL_GREY : SEL_BYPASS;
  endfunction

endpackage

// File: rtl/frame_cfg_sched_sync_edge_det.sv
// One-flop edge detector: combinational rise/fall against the registered copy.
// The input is already synchronous to clk.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_reg <= 1'b0;
    else        d_reg <= din;
  end

  assign rise = din & ~d_reg;
  assign fall = ~din & d_reg;

endmodule

// File: rtl/frame_cfg_sched.sv
// Frame-synchronous configuration scheduler: shadows mode writes and commits them
// only in vertical blanking after the processing pipeline has drained.
module frame_cfg_sched
  import asic_pkg::*;
#(
  parameter int CFG_W        = CFG_W_DEF,
  parameter int DRAIN_CYCLES = 4,
  parameter int FRAME_CNT_W  = 16,
  parameter int LINE_CNT_W   = 12
) (
  input  logic                   clk_sys,
  input  logic                   reset_sys,
  input  logic                   InVSYNC,
  input  logic                   InHSYNC,
  input  logic                   CFG_VALID,
  input  logic [CFG_W-1:0]       CFG_REG,
  output logic [CFG_W-1:0]       mode_active,
  output logic [1:0]             sel_path,
  output logic                   cfg_pending,
  output logic                   cfg_commit,
  output logic                   cfg_miss,
  output logic                   frame_start,
  output logic                   frame_end,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [LINE_CNT_W-1:0]  line_cnt
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  // Index 0 tracks VSYNC, index 1 tracks HSYNC.
  logic [1:0] sync_in;
  logic [1:0] rise;
  logic [1:0] fall;
  logic       v_rise;
  logic       v_fall;
  logic       h_rise;
  logic       unused_h_fall;

  assign sync_in = {InHSYNC, InVSYNC};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
      sync_edge_det u_edge (
        .clk   (clk_sys),
        .rst_n (reset_sys),
        .din   (sync_in[gi]),
        .rise  (rise[gi]),
        .fall  (fall[gi])
      );
    end
  endgenerate

  assign v_rise        = rise[0];
  assign v_fall        = fall[0];
  assign h_rise        = rise[1];
  assign unused_h_fall = fall[1];

  state_t               state_reg, state_next;
  logic [DRAIN_W-1:0]   drain_cnt_reg, drain_cnt_next;
  logic                 commit_en;
  logic                 miss_en;

  logic [CFG_W-1:0]       shadow_reg;
  logic [CFG_W-1:0]       mode_reg;
  logic [1:0]             sel_reg;
  logic                   pending_reg;
  logic                   commit_reg;
  logic                   miss_reg;
  logic                   frame_start_reg;
  logic                   frame_end_reg;
  logic [FRAME_CNT_W-1:0] frame_cnt_reg;
  logic [LINE_CNT_W-1:0]  line_cnt_reg;

  always_ff @(posedge clk_sys or negedge reset_sys) begin
    if (!reset_sys) begin
      state_reg     <= BLANK;
      drain_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BLANK:   if (InVSYNC) state_next = ACTIVE;
      ACTIVE:  if (!InVSYNC) state_next = DRAIN;
      DRAIN: begin
        if (InVSYNC)                    state_next = ACTIVE;
        else if (drain_cnt_reg == '0)   state_next = BLANK;
      end
      default: state_next = BLANK;
    endcase
  end

  // A new frame arriving mid-drain defers the commit; the shadow stays pending.
  always_comb begin
    commit_en      = 1'b0;
    miss_en        = 1'b0;
    drain_cnt_next = drain_cnt_reg;
    case (state_reg)
      BLANK:   commit_en = !InVSYNC && pending_reg;
      ACTIVE:  if (!InVSYNC) drain_cnt_next = DRAIN_LOAD;
      DRAIN: begin
        if (InVSYNC)                  miss_en = pending_reg;
        else if (drain_cnt_reg != '0) drain_cnt_next = drain_cnt_reg - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_sys) begin
    if (!reset_sys) begin
      shadow_reg      <= '0;
      mode_reg        <= '0;
      sel_reg         <= SEL_BYPASS;
      pending_reg     <= 1'b0;
      commit_reg      <= 1'b0;
      miss_reg        <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_end_reg   <= 1'b0;
      frame_cnt_reg   <= '0;
      line_cnt_reg    <= '0;
    end else begin
      // A write on the commit cycle lands in the shadow and stays pending.
      if (CFG_VALID)      pending_reg <= 1'b1;
      else if (commit_en) pending_reg <= 1'b0;
      if (CFG_VALID) shadow_reg <= CFG_REG;
      if (commit_en) begin
        mode_reg <= shadow_reg;
        sel_reg  <= path_of(shadow_reg[1:0]);
      end
      commit_reg      <= commit_en;
      miss_reg        <= miss_en;
      frame_start_reg <= v_rise;
      frame_end_reg   <= v_fall;
      if (v_fall) frame_cnt_reg <= frame_cnt_reg + 1'b1;
      if (v_rise)
        line_cnt_reg <= '0;
      else if (h_rise && InVSYNC && line_cnt_reg != '1)
        line_cnt_reg <= line_cnt_reg + 1'b1;
    end
  end

  assign mode_active = mode_reg;
  assign sel_path    = sel_reg;
  assign cfg_pending = pending_reg;
  assign cfg_commit  = commit_reg;
  assign cfg_miss    = miss_reg;
  assign frame_start = frame_start_reg;
  assign frame_end   = frame_end_reg;
  assign frame_cnt   = frame_cnt_reg;
  assign line_cnt    = line_cnt_reg;

endmodule

// File: tb/tb_frame_cfg_sched.sv
// Self-checking bench for frame_cfg_sched: per-scenario tasks plus a commit scoreboard
// that pairs every cfg_commit pulse with the mode/path expected when the write was driven.
module tb_frame_cfg_sched;

  logic        clk_sys = 1'b0;
  logic        reset_sys;
  logic        InVSYNC;
  logic        InHSYNC;
  logic        CFG_VALID;
  logic [7:0]  CFG_REG;
  logic [7:0]  mode_active;
  logic [1:0]  sel_path;
  logic        cfg_pending;
  logic        cfg_commit;
  logic        cfg_miss;
  logic        frame_start;
  logic        frame_end;
  logic [15:0] frame_cnt;
  logic [11:0] line_cnt;

  typedef struct packed {
    logic [7:0] mode;
    logic [1:0] sel;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [15:0] exp_frame_cnt = '0;

  frame_cfg_sched dut (
    .clk_sys     (clk_sys),
    .reset_sys   (reset_sys),
    .InVSYNC     (InVSYNC),
    .InHSYNC     (InHSYNC),
    .CFG_VALID   (CFG_VALID),
    .CFG_REG     (CFG_REG),
    .mode_active (mode_active),
    .sel_path    (sel_path),
    .cfg_pending (cfg_pending),
    .cfg_commit  (cfg_commit),
    .cfg_miss    (cfg_miss),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .frame_cnt   (frame_cnt),
    .line_cnt    (line_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  // Scoreboard: every commit pulse must match the oldest queued expectation.
  always @(negedge clk_sys) begin
    if (reset_sys === 1'b1 && cfg_commit === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_commit: mode_active=%h sel_path=%b, none expected", mode_active, sel_path);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({mode_active, sel_path} !== {e.mode, e.sel}) begin
          n_fail++;
          $display("FAIL commit_value: got mode=%h sel=%b, expected mode=%h sel=%b",
                   mode_active, sel_path, e.mode, e.sel);
        end else begin
          $display("commit mode=%h sel=%b at %0t", mode_active, sel_path, $time);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset_sys = 1'b0;
    InVSYNC = 1'b0; InHSYNC = 1'b0; CFG_VALID = 1'b0; CFG_REG = 8'h00;
    repeat (3) tick();
    n_checks++;
    if ({mode_active, sel_path} !== 10'd0) begin
      n_fail++; $display("FAIL reset_mode: got %h/%b, expected 00/00", mode_active, sel_path);
    end
    n_checks++;
    if ({cfg_pending, cfg_commit, cfg_miss, frame_start, frame_end} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, expected 00000",
                         {cfg_pending, cfg_commit, cfg_miss, frame_start, frame_end});
    end
    n_checks++;
    if ({frame_cnt, line_cnt} !== 28'd0) begin
      n_fail++; $display("FAIL reset_counters: frame_cnt=%0d line_cnt=%0d, expected 0/0", frame_cnt, line_cnt);
    end
    reset_sys = 1'b1;
    tick();
  endtask

  task automatic test_blank_commit();
    CFG_VALID = 1'b1; CFG_REG = 8'h01;
    exp_q.push_back('{mode: 8'h01, sel: 2'b01});
    tick();
    CFG_VALID = 1'b0;
    n_checks++;
    if (cfg_pending !== 1'b1 || cfg_commit !== 1'b0 || mode_active !== 8'h00) begin
      n_fail++; $display("FAIL blank_pending: pending=%b commit=%b mode=%h, expected 1/0/00",
                         cfg_pending, cfg_commit, mode_active);
    end
    tick();
    n_checks++;
    if (cfg_commit !== 1'b1 || mode_active !== 8'h01 || sel_path !== 2'b01 || cfg_pending !== 1'b0) begin
      n_fail++; $display("FAIL blank_commit: commit=%b mode=%h sel=%b pending=%b, expected 1/01/01/0",
                         cfg_commit, mode_active, sel_path, cfg_pending);
    end
    tick();
    n_checks++;
    if (cfg_commit !== 1'b0) begin
      n_fail++; $display("FAIL blank_commit_pulse: commit=%b, expected 0", cfg_commit);
    end
  endtask

  task automatic test_midframe_write();
    InVSYNC = 1'b1;
    tick();
    n_checks++;
    if (frame_start !== 1'b1) begin
      n_fail++; $display("FAIL mid_frame_start: got %b, expected 1", frame_start);
    end
    CFG_VALID = 1'b1; CFG_REG = 8'h80;
    exp_q.push_back('{mode: 8'h80, sel: 2'b00});
    tick();
    CFG_VALID = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (cfg_pending !== 1'b1 || mode_active !== 8'h01) begin
      n_fail++; $display("FAIL mid_hold: pending=%b mode=%h, expected 1/01", cfg_pending, mode_active);
    end
    InVSYNC = 1'b0;
    exp_frame_cnt++;
    tick();
    n_checks++;
    if (frame_end !== 1'b1 || frame_cnt !== exp_frame_cnt) begin
      n_fail++; $display("FAIL mid_frame_end: frame_end=%b frame_cnt=%0d, expected 1/%0d",
                         frame_end, frame_cnt, exp_frame_cnt);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if (cfg_commit !== 1'b0 || mode_active !== 8'h01) begin
        n_fail++; $display("FAIL mid_drain_%0d: commit=%b mode=%h, expected 0/01", i, cfg_commit, mode_active);
      end
    end
    tick();
    n_checks++;
    if (cfg_commit !== 1'b1 || mode_active !== 8'h80 || sel_path !== 2'b00) begin
      n_fail++; $display("FAIL mid_commit: commit=%b mode=%h sel=%b, expected 1/80/00",
                         cfg_commit, mode_active, sel_path);
    end
    tick();
  endtask

  task automatic test_miss();
    int lat;
    InVSYNC = 1'b1;
    tick();
    CFG_VALID = 1'b1; CFG_REG = 8'h01;
    exp_q.push_back('{mode: 8'h01, sel: 2'b01});
    tick();
    CFG_VALID = 1'b0;
    InVSYNC = 1'b0;
    exp_frame_cnt++;
    tick();
    tick();
    InVSYNC = 1'b1;
    tick();
    n_checks++;
    if (cfg_miss !== 1'b1 || cfg_pending !== 1'b1 || cfg_commit !== 1'b0) begin
      n_fail++; $display("FAIL miss_pulse: miss=%b pending=%b commit=%b, expected 1/1/0",
                         cfg_miss, cfg_pending, cfg_commit);
    end
    tick();
    n_checks++;
    if (cfg_miss !== 1'b0 || mode_active !== 8'h80) begin
      n_fail++; $display("FAIL miss_single: miss=%b mode=%h, expected 0/80", cfg_miss, mode_active);
    end
    repeat (2) tick();
    InVSYNC = 1'b0;
    exp_frame_cnt++;
    lat = 0;
    while (cfg_commit !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat != 6) begin
      n_fail++; $display("FAIL miss_commit_latency: got %0d cycles, expected 6", lat);
    end
    tick();
  endtask

  task automatic test_last_write_wins();
    int lat;
    InVSYNC = 1'b1;
    tick();
    CFG_VALID = 1'b1; CFG_REG = 8'h01;
    tick();
    CFG_REG = 8'h03;
    tick();
    CFG_VALID = 1'b0;
    exp_q.push_back('{mode: 8'h03, sel: 2'b00});
    InVSYNC = 1'b0;
    exp_frame_cnt++;
    lat = 0;
    while (cfg_commit !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat != 6 || mode_active !== 8'h03 || sel_path !== 2'b00) begin
      n_fail++; $display("FAIL last_write: latency=%0d mode=%h sel=%b, expected 6/03/00",
                         lat, mode_active, sel_path);
    end
    n_checks++;
    if (frame_cnt !== exp_frame_cnt) begin
      n_fail++; $display("FAIL last_write_frames: frame_cnt=%0d, expected %0d", frame_cnt, exp_frame_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    CFG_VALID = 1'b1; CFG_REG = 8'hAA;
    exp_q.push_back('{mode: 8'hAA, sel: 2'b00});
    tick();
    CFG_REG = 8'h55;
    exp_q.push_back('{mode: 8'h55, sel: 2'b01});
    tick();
    CFG_VALID = 1'b0;
    n_checks++;
    if (cfg_commit !== 1'b1 || mode_active !== 8'hAA || sel_path !== 2'b00 || cfg_pending !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: commit=%b mode=%h sel=%b pending=%b, expected 1/AA/00/1",
                         cfg_commit, mode_active, sel_path, cfg_pending);
    end
    tick();
    n_checks++;
    if (cfg_commit !== 1'b1 || mode_active !== 8'h55 || sel_path !== 2'b01 || cfg_pending !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second: commit=%b mode=%h sel=%b pending=%b, expected 1/55/01/0",
                         cfg_commit, mode_active, sel_path, cfg_pending);
    end
    tick();
  endtask

  task automatic test_lines();
    InVSYNC = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      InHSYNC = 1'b1; tick();
      InHSYNC = 1'b0; tick();
    end
    n_checks++;
    if (line_cnt !== 12'd5) begin
      n_fail++; $display("FAIL line_count: got %0d, expected 5", line_cnt);
    end
    InVSYNC = 1'b0;
    exp_frame_cnt++;
    tick();
    n_checks++;
    if (frame_end !== 1'b1 || frame_cnt !== exp_frame_cnt || line_cnt !== 12'd5) begin
      n_fail++; $display("FAIL line_frame_end: frame_end=%b frame_cnt=%0d line_cnt=%0d, expected 1/%0d/5",
                         frame_end, frame_cnt, line_cnt, exp_frame_cnt);
    end
    repeat (6) tick();
    InVSYNC = 1'b1;
    tick();
    n_checks++;
    if (frame_start !== 1'b1 || line_cnt !== 12'd0) begin
      n_fail++; $display("FAIL line_clear: frame_start=%b line_cnt=%0d, expected 1/0", frame_start, line_cnt);
    end
    for (int i = 0; i < 4100; i++) begin
      InHSYNC = 1'b1; tick();
      InHSYNC = 1'b0; tick();
    end
    n_checks++;
    if (line_cnt !== 12'hFFF) begin
      n_fail++; $display("FAIL line_saturate: got %0d, expected 4095", line_cnt);
    end
    InVSYNC = 1'b0;
    exp_frame_cnt++;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid_drain();
    InVSYNC = 1'b1;
    tick();
    CFG_VALID = 1'b1; CFG_REG = 8'h01;
    tick();
    CFG_VALID = 1'b0;
    InVSYNC = 1'b0;
    tick();
    tick();
    reset_sys = 1'b0;
    #1;
    n_checks++;
    if ({mode_active, sel_path, cfg_pending, cfg_commit, cfg_miss, frame_start, frame_end} !== 15'd0
        || {frame_cnt, line_cnt} !== 28'd0) begin
      n_fail++; $display("FAIL drain_reset: mode=%h sel=%b pending=%b frame_cnt=%0d line_cnt=%0d, expected all 0",
                         mode_active, sel_path, cfg_pending, frame_cnt, line_cnt);
    end
    exp_frame_cnt = '0;
    InVSYNC = 1'b1;
    tick();
    reset_sys = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (cfg_commit !== 1'b0 || cfg_pending !== 1'b0 || mode_active !== 8'h00) begin
        n_fail++; $display("FAIL post_reset_active_%0d: commit=%b pending=%b mode=%h, expected 0/0/00",
                           i, cfg_commit, cfg_pending, mode_active);
      end
    end
    InVSYNC = 1'b0;
    exp_frame_cnt++;
    tick();
    n_checks++;
    if (frame_end !== 1'b1 || frame_cnt !== exp_frame_cnt) begin
      n_fail++; $display("FAIL post_reset_frame: frame_end=%b frame_cnt=%0d, expected 1/%0d",
                         frame_end, frame_cnt, exp_frame_cnt);
    end
    repeat (8) tick();
    n_checks++;
    if (mode_active !== 8'h00 || sel_path !== 2'b00) begin
      n_fail++; $display("FAIL post_reset_mode: mode=%h sel=%b, expected 00/00", mode_active, sel_path);
    end
  endtask

  initial begin
    test_reset();
    test_blank_commit();
    test_midframe_write();
    test_miss();
    test_last_write_wins();
    test_back_to_back();
    test_lines();
    test_reset_mid_drain();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drained: %0d commits outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
